lcd_multi_channel_display: RTL and testbench
============================================

# lcd_multi_channel_display

Parametrised HD44780-class character LCD driver that continuously shows N_CH 16-bit sensor channels as labelled decimal fields ("Sk:ddd") on a 2x16 display. It replaces the fixed three-channel LCD controller in the sensor display path. Additions over that controller:
- proper E-strobe setup/hold timing
- power-up and clear waits
- per-frame value snapshot
- sequential binary-to-BCD conversion
- leading-zero blanking
- over-range indication
- a frame-done status pulse

## Interface
- TICK_DIV, 50000: clk cycles per LCD step (one command/char write or one wait slot); must be ≥ 24.
- N_CH, 3: number of channels, 1..4.
- DIGITS, 3: decimal digits per field, 1..4.
- LZ_BLANK, 1: 1 = replace leading zeros with spaces (least significant digit always shown).
- PWRUP_STEPS, 20: idle steps after reset before the first init command.
- CLR_STEPS, 2: extra idle steps after the Clear command.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low.
- val  input  16*N_CH  packed channel values; channel k = val[16k+15:16k].
- rs  output  1  LCD register select (0 = command, 1 = data).
- rw  output  1  LCD read/write; constant 0.
- en  output  1  LCD enable strobe.
- data  output  8  LCD data bus.
- init_done  output  1  high once the init sequence has completed; stays high until reset.
- frame_done  output  1  one-clk pulse at the end of each full frame.

## Operation
- Reset values: rs=0, rw=0, en=0, data=8'h00, init_done=0, frame_done=0. FSM returns to PWR_WAIT and all counters clear. Reset asserted mid-step or mid-frame aborts immediately.
- Step timer: counts 0..TICK_DIV-1. FSM actions happen at count 0.
- FSM states and transitions:
  - PWR_WAIT: PWRUP_STEPS steps, no strobe.
  - INIT: commands 0x38, 0x38, 0x0C, 0x01.
  - CLR_WAIT: CLR_STEPS steps, no strobe.
  - INIT: command 0x06, then init_done=1.
  - FRAME_START: snapshot all of val into internal registers; channel index k=0. This step writes nothing.
  - For each k = 0..N_CH-1:
    - CONV: sequential double-dabble on snap[k], 16 iterations, one per clk, completing within this step. Nothing is written.
    - ADDR: command 0x80 | (0x40·(k/2)) | (8·(k%2)).
    - LABEL: data "S", ASCII '1'+k, ":".
    - DIGIT: DIGITS chars, most significant first.
  - FRAME_END: frame_done pulse (one clk), then loop to FRAME_START. Init is not repeated.
- Digit encoding:
  - Normal digit: 8'h30 + BCD digit.
  - Over-range (snap[k] ≥ 10^DIGITS): all DIGITS chars are '-' (8'h2D).
  - LZ_BLANK=1: zeros before the first nonzero digit become ' ' (8'h20). A value of 0 shows spaces then a single '0'.
- Field layout: field width is 3+DIGITS ≤ 7 chars at columns 0 or 8, so there is no overlap. Columns not written are left untouched.
- val may change at any time. Displayed values change only at FRAME_START, so every field within a frame is coherent.

## Timing
- Write step, relative to step start (cycle 0):
  - rs and data update at cycle 0.
  - en=1 for cycles 1..TICK_DIV/2.
  - en=0 from cycle TICK_DIV/2+1 through the end of the step.
  - rs and data are held stable for the whole step, which gives 1 clk setup and ≥ TICK_DIV/2-1 clk hold.
- Non-write steps (PWR_WAIT, CLR_WAIT, FRAME_START, CONV): en stays 0 and data/rs hold their previous values.
- Steps per frame: 2 + N_CH·(5+DIGITS), counting FRAME_START, FRAME_END, and per channel CONV + ADDR + 3 label + DIGITS.
- Latency from reset release to the first en rise: (PWRUP_STEPS)·TICK_DIV + 1 clk.
- frame_done fires at cycle 0 of the FRAME_END step.
- Value-to-display latency: at most 2 frames.

## Test plan
- Init: TICK_DIV=24, release reset.
  - en stays low for 20·24 cycles.
  - Writes then occur in order 0x38, 0x38, 0x0C, 0x01 (rs=0).
  - 2 silent steps follow, then 0x06.
  - init_done rises after 0x06.
- Strobe timing: on every write, data/rs are stable from 1 clk before en rises until the end of the step. en is high exactly 12 clks, and rw is always 0.
- Frame content, N_CH=3, DIGITS=3, LZ_BLANK=0, val={16'd7, 16'd45, 16'd123}:
  - Write sequence: 0x80 "S1:123", 0x88 "S2:045", 0xC0 "S3:007".
  - frame_done pulses once per 26 steps.
- Blanking/over-range, LZ_BLANK=1:
  - val0=0 → "  0"
  - val0=5 → "  5"
  - val0=999 → "999"
  - val0=1000 → "---"
  - val0=16'hFFFF → "---"
- Snapshot: change val1 from 45 to 678 while channel 1's digits are being written. The current frame still shows "045"; the next frame shows "678".
- Reset mid-frame: assert reset during a DIGIT step. All outputs go to reset values asynchronously, and after release the full init sequence repeats from PWR_WAIT.

Source files
------------

// File: rtl/lcd_multi_channel_display.sv
// HD44780-class 2x16 character LCD driver: init sequence, then an endless loop of
// frames showing N_CH snapshotted 16-bit channels as "Sk:ddd" decimal fields.
module lcd_multi_channel_display #(
    parameter int TICK_DIV    = 50000,
    parameter int N_CH        = 3,
    parameter int DIGITS      = 3,
    parameter int LZ_BLANK    = 1,
    parameter int PWRUP_STEPS = 20,
    parameter int CLR_STEPS   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [16*N_CH-1:0]   val,
    output logic                 rs,
    output logic                 rw,
    output logic                 en,
    output logic [7:0]           data,
    output logic                 init_done,
    output logic                 frame_done
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = 16;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
    localparam logic [TW-1:0] CONV_LAST = TW'(16);

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT,
        CLR_WAIT,
        FRAME_START,
        CONV,
        ADDR,
        LABEL,
        DIGIT,
        FRAME_END
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [SW-1:0]   sub_q;
    logic [1:0]      k_q;
    logic            wr_q;
    logic            rs_q;
    logic            en_q;
    logic [7:0]      data_q;
    logic            init_done_q;
    logic            frame_done_q;

    logic [15:0]     snap_q [N_CH];
    logic [15:0]     snap_sel;
    logic [15:0]     bin_q;
    logic [19:0]     bcd_q;
    logic            step_end;

    assign step_end   = (tick_q == TICK_LAST);
    assign rs         = rs_q;
    assign rw         = 1'b0;
    assign en         = en_q;
    assign data       = data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

    function automatic logic [7:0] init_cmd(input logic [SW-1:0] idx);
        case (idx)
            16'd0, 16'd1: return 8'h38;
            16'd2:        return 8'h0C;
            16'd3:        return 8'h01;
            default:      return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input logic [1:0] k);
        return 8'h80 | (k[1] ? 8'h40 : 8'h00) | (k[0] ? 8'h08 : 8'h00);
    endfunction

    // One double-dabble iteration: add-3 correction on every BCD digit, then shift.
    function automatic logic [35:0] dd_step(input logic [19:0] bcd, input logic [15:0] bin);
        logic [19:0] b;
        b = bcd;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) b[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return {b, bin} << 1;
    endfunction

    // Character for digit position pos (0 = most significant) of the converted value.
    function automatic logic [7:0] digit_char(input logic [19:0] bcd, input int pos);
        int         d;
        logic       over;
        logic       lead;
        logic [3:0] nib;
        d    = DIGITS - 1 - pos;
        over = |(bcd >> (4 * DIGITS));
        lead = (LZ_BLANK != 0) && (d != 0);
        for (int i = 0; i < 4; i++) begin
            if (i < DIGITS && i >= d && 4'(bcd >> (4 * i)) != 4'd0) lead = 1'b0;
        end
        nib = 4'(bcd >> (4 * d));
        if (over) return 8'h2D;
        if (lead) return 8'h20;
        return 8'h30 + {4'h0, nib};
    endfunction

    always_comb begin
        snap_sel = snap_q[0];
        for (int i = 1; i < N_CH; i++) begin
            if (k_q == 2'(i)) snap_sel = snap_q[i];
        end
    end

    // Step sequencer: registered LCD outputs change on the edge that starts a step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PWR_WAIT;
            tick_q       <= '0;
            sub_q        <= '0;
            k_q          <= '0;
            wr_q         <= 1'b0;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            tick_q       <= step_end ? '0 : tick_q + 1'b1;

            if (tick_q == '0 && wr_q) en_q <= 1'b1;
            else if (tick_q == TICK_HALF) en_q <= 1'b0;

            if (step_end) begin
                wr_q <= 1'b0;
                case (state_q)
                    PWR_WAIT: begin
                        if (sub_q == SW'(PWRUP_STEPS - 1)) begin
                            state_q <= INIT;
                            sub_q   <= '0;
                            rs_q    <= 1'b0;
                            data_q  <= init_cmd('0);
                            wr_q    <= 1'b1;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                    INIT: begin
                        if (sub_q == SW'(3)) begin
                            state_q <= CLR_WAIT;
                            sub_q   <= '0;
                        end else if (sub_q == SW'(4)) begin
                            state_q     <= FRAME_START;
                            sub_q       <= '0;
                            init_done_q <= 1'b1;
                        end else begin
                            sub_q  <= sub_q + 1'b1;
                            rs_q   <= 1'b0;
                            data_q <= init_cmd(sub_q + 1'b1);
                            wr_q   <= 1'b1;
                        end
                    end
                    CLR_WAIT: begin
                        if (sub_q == SW'(CLR_STEPS - 1)) begin
                            state_q <= INIT;
                            sub_q   <= SW'(4);
                            rs_q    <= 1'b0;
                            data_q  <= init_cmd(SW'(4));
                            wr_q    <= 1'b1;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                    FRAME_START: begin
                        state_q <= CONV;
                        k_q     <= '0;
                    end
                    CONV: begin
                        state_q <= ADDR;
                        rs_q    <= 1'b0;
                        data_q  <= addr_cmd(k_q);
                        wr_q    <= 1'b1;
                    end
                    ADDR: begin
                        state_q <= LABEL;
                        sub_q   <= '0;
                        rs_q    <= 1'b1;
                        data_q  <= 8'h53;
                        wr_q    <= 1'b1;
                    end
                    LABEL: begin
                        rs_q <= 1'b1;
                        wr_q <= 1'b1;
                        if (sub_q == SW'(0)) begin
                            sub_q  <= SW'(1);
                            data_q <= 8'h31 + {6'd0, k_q};
                        end else if (sub_q == SW'(1)) begin
                            sub_q  <= SW'(2);
                            data_q <= 8'h3A;
                        end else begin
                            state_q <= DIGIT;
                            sub_q   <= '0;
                            data_q  <= digit_char(bcd_q, 0);
                        end
                    end
                    DIGIT: begin
                        if (sub_q == SW'(DIGITS - 1)) begin
                            if (k_q == 2'(N_CH - 1)) begin
                                state_q      <= FRAME_END;
                                frame_done_q <= 1'b1;
                            end else begin
                                state_q <= CONV;
                                k_q     <= k_q + 2'd1;
                            end
                        end else begin
                            sub_q  <= sub_q + 1'b1;
                            rs_q   <= 1'b1;
                            data_q <= digit_char(bcd_q, int'(sub_q) + 1);
                            wr_q   <= 1'b1;
                        end
                    end
                    FRAME_END: begin
                        state_q <= FRAME_START;
                    end
                    default: begin
                        state_q <= PWR_WAIT;
                        sub_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Datapath: frame snapshot at FRAME_START, 16 conversion iterations early in CONV.
    always_ff @(posedge clk) begin
        if (state_q == FRAME_START && tick_q == '0) begin
            for (int i = 0; i < N_CH; i++) snap_q[i] <= val[16*i +: 16];
        end
        if (state_q == CONV) begin
            if (tick_q == '0) begin
                bin_q <= snap_sel;
                bcd_q <= '0;
            end else if (tick_q <= CONV_LAST) begin
                {bcd_q, bin_q} <= dd_step(bcd_q, bin_q);
            end
        end
    end

endmodule

// File: tb/tb_lcd_multi_channel_display.sv
// Bench for lcd_multi_channel_display: two instances (no blanking / blanking) with a
// write-stream scoreboard, strobe-timing monitor and table-driven blanking vectors.
module tb_lcd_multi_channel_display;

    localparam int TD = 24;
    localparam int NC = 3;
    localparam int DG = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [16*NC-1:0] val_a, val_b;
    logic            rs_a, rw_a, en_a, idn_a, fd_a;
    logic            rs_b, rw_b, en_b, idn_b, fd_b;
    logic [7:0]      data_a, data_b;

    lcd_multi_channel_display #(.TICK_DIV(TD), .N_CH(NC), .DIGITS(DG), .LZ_BLANK(0),
        .PWRUP_STEPS(20), .CLR_STEPS(2)) dut_a (
        .clk(clk), .reset(reset), .val(val_a), .rs(rs_a), .rw(rw_a), .en(en_a),
        .data(data_a), .init_done(idn_a), .frame_done(fd_a));

    lcd_multi_channel_display #(.TICK_DIV(TD), .N_CH(NC), .DIGITS(DG), .LZ_BLANK(1),
        .PWRUP_STEPS(20), .CLR_STEPS(2)) dut_b (
        .clk(clk), .reset(reset), .val(val_b), .rs(rs_b), .rw(rw_b), .en(en_b),
        .data(data_b), .init_done(idn_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] qa[$];
    logic [8:0] qb[$];

    logic       p_en [2];
    logic       p_rs [2];
    logic [7:0] p_data [2];
    logic [8:0] held [2];
    int         hold [2];
    int         hi_cnt [2];
    bit         in_wr [2];
    bit         stable [2];
    int         wr_cnt [2];
    int         rise_n [2];
    longint     rise_t [2][8];

    typedef struct {
        logic [15:0] v;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_w(input int d, input logic [8:0] w);
        if (d == 0) qa.push_back(w);
        else qb.push_back(w);
    endtask

    function automatic logic [23:0] field(input int v, input bit lz);
        logic [23:0] s;
        int          dig [3];
        bit          lead;
        if (v >= 1000) return {3{8'h2D}};
        dig[0] = v / 100;
        dig[1] = (v / 10) % 10;
        dig[2] = v % 10;
        lead   = lz;
        s      = '0;
        for (int i = 0; i < 3; i++) begin
            if (lead && dig[i] == 0 && i < 2) s[23-8*i -: 8] = 8'h20;
            else begin
                lead = 1'b0;
                s[23-8*i -: 8] = 8'h30 + 8'(dig[i]);
            end
        end
        return s;
    endfunction

    task automatic push_init(input int d);
        push_w(d, {1'b0, 8'h38});
        push_w(d, {1'b0, 8'h38});
        push_w(d, {1'b0, 8'h0C});
        push_w(d, {1'b0, 8'h01});
        push_w(d, {1'b0, 8'h06});
    endtask

    task automatic push_frame(input int d, input logic [23:0] f0, input int v1, input int v2,
                              input bit lz);
        logic [23:0] f;
        logic [7:0]  ad;
        for (int k = 0; k < NC; k++) begin
            ad = 8'h80 | ((k / 2) != 0 ? 8'h40 : 8'h00) | ((k % 2) != 0 ? 8'h08 : 8'h00);
            push_w(d, {1'b0, ad});
            push_w(d, {1'b1, 8'h53});
            push_w(d, {1'b1, 8'h31 + 8'(k)});
            push_w(d, {1'b1, 8'h3A});
            f = (k == 0) ? f0 : field((k == 1) ? v1 : v2, lz);
            for (int j = 0; j < 3; j++) push_w(d, {1'b1, f[23-8*j -: 8]});
        end
    endtask

    task automatic mon(input int d, input logic e, input logic r, input logic [7:0] dt,
                       input logic w);
        logic [8:0] exp;
        if (e && !p_en[d]) begin
            chk($sformatf("setup%0d", d), {p_rs[d], p_data[d]}, {r, dt});
            chk($sformatf("rw%0d", d), w, 0);
            if (rise_n[d] < 8) rise_t[d][rise_n[d]] = cyc;
            rise_n[d]++;
            wr_cnt[d]++;
            if (d == 0 && qa.size() > 0) begin
                exp = qa.pop_front();
                chk("write0", {r, dt}, exp);
            end else if (d == 1 && qb.size() > 0) begin
                exp = qb.pop_front();
                chk("write1", {r, dt}, exp);
            end
            held[d]   = {r, dt};
            hold[d]   = TD - 2;
            stable[d] = 1'b1;
            in_wr[d]  = 1'b1;
            hi_cnt[d] = 1;
        end else begin
            if (in_wr[d]) begin
                if (e) hi_cnt[d]++;
                else begin
                    chk($sformatf("en_width%0d", d), hi_cnt[d], TD / 2);
                    in_wr[d] = 1'b0;
                end
            end
            if (hold[d] > 0) begin
                if ({r, dt} != held[d]) stable[d] = 1'b0;
                hold[d]--;
                if (hold[d] == 0) chk($sformatf("hold%0d", d), stable[d], 1);
            end
        end
        p_en[d]   = e;
        p_rs[d]   = r;
        p_data[d] = dt;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                p_en[i] = 1'b0; p_rs[i] = 1'b0; p_data[i] = 8'h00;
                hold[i] = 0; in_wr[i] = 1'b0; rise_n[i] = 0;
            end
        end else begin
            mon(0, en_a, rs_a, data_a, rw_a);
            mon(1, en_b, rs_b, data_b, rw_b);
        end
    end

    task automatic wait_fd(input int d, output longint t);
        int n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((d == 0) ? fd_a : fd_b) break;
            if (n > 3000) break;
        end
        if (n > 3000) begin
            checks++; errors++;
            $display("FAIL frame_done%0d timeout: got none required pulse", d);
        end
        t = cyc;
    endtask

    task automatic wait_wr(input int d, input int target);
        int n = 0;
        while (wr_cnt[d] < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (wr_cnt[d] < target) begin
            checks++; errors++;
            $display("FAIL writes%0d timeout: got %0d required %0d", d, wr_cnt[d], target);
        end
    endtask

    task automatic check_latency(input string nm);
        int n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (en_a) break;
        end
        chk(nm, n, 20 * TD + 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_rs"}, rs_a, 0);
        chk({nm, "_rw"}, rw_a, 0);
        chk({nm, "_en"}, en_a, 0);
        chk({nm, "_data"}, data_a, 0);
        chk({nm, "_init_done"}, idn_a, 0);
        chk({nm, "_frame_done"}, fd_a, 0);
        chk({nm, "_en_b"}, en_b, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        longint t1, t2;
        int     base;

        tbl[0] = '{16'd0,     "  0"};
        tbl[1] = '{16'd5,     "  5"};
        tbl[2] = '{16'd999,   "999"};
        tbl[3] = '{16'd1000,  "---"};
        tbl[4] = '{16'hFFFF,  "---"};
        for (int i = 0; i < 2; i++) wr_cnt[i] = 0;

        val_a = {16'd7, 16'd45, 16'd123};
        val_b = {16'hFFFF, 16'd10, 16'd0};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        push_init(0);
        push_frame(0, "123", 45, 7, 0);
        push_frame(0, "123", 45, 7, 0);
        push_frame(0, "123", 678, 7, 0);
        push_init(1);

        #2 reset = 1'b1;
        check_latency("first_en");
        wait_wr(0, 5);
        chk("init_done_at_06", idn_a, 0);
        chk("gap01", rise_t[0][1] - rise_t[0][0], TD);
        chk("gap12", rise_t[0][2] - rise_t[0][1], TD);
        chk("gap23", rise_t[0][3] - rise_t[0][2], TD);
        chk("gap_clr", rise_t[0][4] - rise_t[0][3], 3 * TD);
        repeat (2 * TD) @(negedge clk);
        chk("init_done_after", idn_a, 1);

        // Change channel 1 while its digits of frame 2 are on the bus.
        wait_wr(0, 5 + 21 + 12);
        val_a[31:16] = 16'd678;

        wait_fd(0, t1);
        @(negedge clk);
        chk("fd_width", fd_a, 0);
        wait_fd(0, t2);
        chk("frame_period", t2 - t1, (2 + NC * (5 + DG)) * TD);
        chk("qa_drained", qa.size(), 0);

        for (int i = 0; i < 5; i++) begin
            wait_fd(1, t1);
            val_b[15:0] = tbl[i].v;
            push_frame(1, tbl[i].exp, 10, 65535, 1);
        end
        wait_fd(1, t1);
        chk("qb_drained", qb.size(), 0);

        // Abort in the middle of a DIGIT write while en is high.
        wait_fd(0, t1);
        base = wr_cnt[0];
        wait_wr(0, base + 5);
        repeat (3) @(negedge clk);
        chk("pre_rst_en", en_a, 1);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid");
        qa.delete();
        qb.delete();
        push_init(0);
        push_init(1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        check_latency("re_first_en");
        wait_wr(0, wr_cnt[0] + 5);
        chk("re_qa_drained", qa.size(), 0);
        chk("re_init_done_at_06", idn_a, 0);
        repeat (2 * TD) @(negedge clk);
        chk("re_init_done_after", idn_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
